alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Parametrised successor to the combinational ALU-control decode: decodes {ALUOp, ALUFunction} and executes the operation in one sequential unit.
- Single-cycle ops return registered results after 1 cycle.
- MULTU/DIVU run iteratively (shift-add / restoring division) into HI/LO registers, with busy/done handshake.
- Sits in the EX stage of the multi-cycle MIPS datapath; the control FSM stalls on busy.

Parameters:
- DATA_WIDTH, 32, operand/result width (must be >= 8, power of 2).
- SHAMT_WIDTH, $clog2(DATA_WIDTH), shift-amount width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  issue strobe; sampled only when busy=0.
- ALUOp  in  3  op class from main control (111 = R-type, 100 ADDI, 101 ORI, 110 ANDI, 011 LUI).
- ALUFunction  in  6  instruction funct field (used only when ALUOp=111).
- shamt  in  SHAMT_WIDTH  shift amount for SLL/SRL.
- a  in  DATA_WIDTH  operand A (rs).
- b  in  DATA_WIDTH  operand B (rt or extended immediate).
- result  out  DATA_WIDTH  registered result.
- zero  out  1  result == 0, registered with result.
- busy  out  1  iterative op in progress.
- done  out  1  one-cycle pulse when result/HI/LO are valid.
- illegal  out  1  one-cycle pulse, undecodable selector.
- div_zero  out  1  one-cycle pulse, DIVU with b=0.
- hi  out  DATA_WIDTH  HI register.
- lo  out  DATA_WIDTH  LO register.

Behaviour:
- Reset (async, any state): FSM→IDLE; result, hi, lo, counter, internal regs = 0; zero=1; busy, done, illegal, div_zero = 0.
- Decode (casex on 9-bit {ALUOp, ALUFunction}):
  - R-type: AND 100100, OR 100101, NOR 100111, ADD 100000, SUB 100010, SLT 101010 (signed), SLL 000000, SRL 000010, MFHI 010000, MFLO 010010, MULTU 011001, DIVU 011011.
  - I-type: ADDI→add, ORI→or, ANDI→and, LUI→b << (DATA_WIDTH/2).
- Arithmetic: wrap modulo 2^DATA_WIDTH, no overflow trap. SLT returns 1 or 0 zero-extended. Shifts are logical, by shamt.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE, start=1, single-cycle op:
  - result/zero register at that edge; done=1 for the following cycle; stay IDLE.
  - Latency 1; back-to-back issue allowed every cycle.
- IDLE, start=1, MULTU:
  - Latch a, b; clear accumulator; counter=0; →MUL.
  - busy=1 from the next cycle.
- MUL: one partial-product step per cycle. After DATA_WIDTH steps, {hi, lo} = a*b (unsigned 2W product), →DONE.
- IDLE, start=1, DIVU, b≠0:
  - →DIV; one restoring step per cycle for DATA_WIDTH cycles.
  - Then lo = a/b, hi = a%b, →DONE.
- IDLE, start=1, DIVU, b=0:
  - Completes in 1 cycle: hi=a, lo=all ones, div_zero and done pulse, stay IDLE.
- DONE: busy=0, done=1 for exactly this cycle; →IDLE. result is unchanged by MULTU/DIVU.
- Iterative latency: start edge k → done high in cycle k+DATA_WIDTH+1. busy is high for cycles k+1 … k+DATA_WIDTH.
- start while busy=1: ignored entirely; no state, result, hi, or lo change.
- MFHI/MFLO read the committed hi/lo. They are issuable the cycle done is high, because start is sampled in DONE→IDLE; the new hi/lo are visible.
- Illegal selector with start=1:
  - result=0, zero=1, illegal and done pulse together.
  - hi/lo unchanged.
- Reset asserted mid-MUL/DIV: operation aborted, hi/lo=0, no done pulse.
- start=0 in IDLE: all outputs hold, pulses low.

Decomposition:
- Package alu_exec_pkg holds:
  - ALUOp class constants (R_TYPE=3'b111, I_ADDI, I_ORI, I_ANDI, I_LUI).
  - funct constants.
  - Internal op enum (OP_AND … OP_DIVU, OP_ILLEGAL).
  - FSM state enum.
- One sub-module: alu_exec_decode, purely combinational {ALUOp, ALUFunction} → op enum + is_iterative. It is the parametrised successor of the existing decode table.
- Datapath and FSM live in alu_exec_unit.

Test Plan:
- Reset mid-MULTU (a=7, b=9, reset at cycle 5) → busy=0, hi=lo=0, no done. Then ADD a=5, b=3 → result=8, zero=0, done at +1 cycle.
- Single-cycle sweep, DATA_WIDTH=32:
  - SUB a=3, b=3 → result=0, zero=1.
  - SLT a=0xFFFFFFFF, b=1 → 1.
  - SLL shamt=4, b=0x1 → 0x10.
  - LUI b=0x1234 → 0x12340000.
  - NOR a=0, b=0 → 0xFFFFFFFF.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF, start at edge k → busy cycles k+1..k+32, done at k+33, hi=0xFFFFFFFE, lo=0x00000001. A second start at k+5 (ADD) is ignored.
- DIVU a=100, b=7 → lo=14, hi=2 after 32 busy cycles. MFLO issued in the done cycle → result=14 one cycle later.
- DIVU a=55, b=0 → 1 cycle: div_zero=1, done=1, hi=55, lo=0xFFFFFFFF.
- Illegal selector {111, 111111} → illegal=1, done=1, result=0, hi/lo unchanged. Repeat the sweep with DATA_WIDTH=16: MULTU 0xFFFF*0x0002 → hi=0x0001, lo=0xFFFE, done at k+17.

Source files
------------

// File: rtl/alu_exec_pkg.sv
// Shared constants and enums for the EX-stage ALU execution unit.
package alu_exec_pkg;

  localparam logic [2:0] R_TYPE = 3'b111;
  localparam logic [2:0] I_ADDI = 3'b100;
  localparam logic [2:0] I_ORI  = 3'b101;
  localparam logic [2:0] I_ANDI = 3'b110;
  localparam logic [2:0] I_LUI  = 3'b011;

  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [3:0] {
    OP_AND, OP_OR, OP_NOR, OP_ADD, OP_SUB, OP_SLT, OP_SLL, OP_SRL,
    OP_MFHI, OP_MFLO, OP_LUI, OP_MULTU, OP_DIVU, OP_ILLEGAL
  } op_e;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_e;

endpackage

// File: rtl/alu_exec_decode.sv
// Combinational decode of {ALUOp, funct} into the internal operation.
module alu_exec_decode
  import alu_exec_pkg::*;
(
  input  logic [2:0] alu_op,
  input  logic [5:0] alu_funct,
  output op_e        op,
  output logic       is_iterative
);

  always_comb begin
    op = OP_ILLEGAL;
    casez ({alu_op, alu_funct})
      {R_TYPE, F_AND}:   op = OP_AND;
      {R_TYPE, F_OR}:    op = OP_OR;
      {R_TYPE, F_NOR}:   op = OP_NOR;
      {R_TYPE, F_ADD}:   op = OP_ADD;
      {R_TYPE, F_SUB}:   op = OP_SUB;
      {R_TYPE, F_SLT}:   op = OP_SLT;
      {R_TYPE, F_SLL}:   op = OP_SLL;
      {R_TYPE, F_SRL}:   op = OP_SRL;
      {R_TYPE, F_MFHI}:  op = OP_MFHI;
      {R_TYPE, F_MFLO}:  op = OP_MFLO;
      {R_TYPE, F_MULTU}: op = OP_MULTU;
      {R_TYPE, F_DIVU}:  op = OP_DIVU;
      {I_ADDI, 6'b??????}: op = OP_ADD;
      {I_ORI,  6'b??????}: op = OP_OR;
      {I_ANDI, 6'b??????}: op = OP_AND;
      {I_LUI,  6'b??????}: op = OP_LUI;
      default:             op = OP_ILLEGAL;
    endcase
    is_iterative = (op == OP_MULTU) || (op == OP_DIVU);
  end

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: single-cycle ops plus iterative MULTU/DIVU into HI/LO.
// state   | meaning
// IDLE    | accepts start; single-cycle ops and DIVU-by-zero complete here
// MUL     | one shift-add step per cycle, busy=1
// DIV     | one restoring-division step per cycle, busy=1
// DONE    | HI/LO committed, done pulse visible; accepts start like IDLE
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [2:0]             ALUOp,
  input  logic [5:0]             ALUFunction,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  input  logic [DATA_WIDTH-1:0]  a,
  input  logic [DATA_WIDTH-1:0]  b,
  output logic [DATA_WIDTH-1:0]  result,
  output logic                   zero,
  output logic                   busy,
  output logic                   done,
  output logic                   illegal,
  output logic                   div_zero,
  output logic [DATA_WIDTH-1:0]  hi,
  output logic [DATA_WIDTH-1:0]  lo
);

  localparam int W = DATA_WIDTH;

  op_e    op;
  logic   is_iterative;
  state_e state;

  logic [2*W-1:0]         acc;
  logic [W-1:0]           opnd;
  logic [SHAMT_WIDTH-1:0] cnt;
  logic [W-1:0]           alu_res;
  logic [W:0]             mul_sum, div_shift, div_diff;
  logic [2*W-1:0]         acc_mul, acc_div;
  logic                   last_step;

  alu_exec_decode u_decode (
    .alu_op      (ALUOp),
    .alu_funct   (ALUFunction),
    .op          (op),
    .is_iterative(is_iterative)
  );

  always_comb begin
    alu_res = '0;
    case (op)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_NOR:  alu_res = ~(a | b);
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_SLT:  alu_res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL:  alu_res = b << shamt;
      OP_SRL:  alu_res = b >> shamt;
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      OP_LUI:  alu_res = b << (W/2);
      default: alu_res = '0;
    endcase
  end

  // acc holds {partial product, unconsumed multiplier} for MUL and
  // {remainder, dividend/quotient} for DIV; opnd is the multiplicand/divisor.
  always_comb begin
    mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
    acc_mul   = {mul_sum, acc[W-1:1]};
    div_shift = acc[2*W-1:W-1];
    div_diff  = div_shift - {1'b0, opnd};
    acc_div   = div_diff[W] ? {div_shift[W-1:0], acc[W-2:0], 1'b0}
                            : {div_diff[W-1:0],  acc[W-2:0], 1'b1};
    last_step = (cnt == SHAMT_WIDTH'(W - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      result   <= '0;
      zero     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      illegal  <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      acc      <= '0;
      opnd     <= '0;
      cnt      <= '0;
    end else begin
      done     <= 1'b0;
      illegal  <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          state <= ST_IDLE;
          if (start) begin
            if (is_iterative) begin
              if (op == OP_MULTU) begin
                acc   <= {{W{1'b0}}, b};
                opnd  <= a;
                cnt   <= '0;
                busy  <= 1'b1;
                state <= ST_MUL;
              end else if (b != '0) begin
                acc   <= {{W{1'b0}}, a};
                opnd  <= b;
                cnt   <= '0;
                busy  <= 1'b1;
                state <= ST_DIV;
              end else begin
                hi       <= a;
                lo       <= '1;
                div_zero <= 1'b1;
                done     <= 1'b1;
              end
            end else if (op == OP_ILLEGAL) begin
              result  <= '0;
              zero    <= 1'b1;
              illegal <= 1'b1;
              done    <= 1'b1;
            end else begin
              result <= alu_res;
              zero   <= (alu_res == '0);
              done   <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          acc <= acc_mul;
          cnt <= cnt + 1'b1;
          if (last_step) begin
            {hi, lo} <= acc_mul;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= ST_DONE;
          end
        end
        ST_DIV: begin
          acc <= acc_div;
          cnt <= cnt + 1'b1;
          if (last_step) begin
            {hi, lo} <= acc_div;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit at DATA_WIDTH 32 and 16.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start16;
  logic [2:0]  alu_op;
  logic [5:0]  alu_fn;
  logic [4:0]  shamt;
  logic [3:0]  shamt16;
  logic [31:0] a, b;
  logic [15:0] a16, b16;
  logic [31:0] result, hi, lo;
  logic [15:0] result16, hi16, lo16;
  logic        zero, busy, done, illegal, div_zero;
  logic        zero16, busy16, done16, illegal16, div_zero16;

  int n_cmp = 0;
  int n_err = 0;
  int n;
  bit early;

  always #5 clk = ~clk;

  alu_exec_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .ALUOp(alu_op), .ALUFunction(alu_fn),
    .shamt(shamt), .a(a), .b(b), .result(result), .zero(zero), .busy(busy),
    .done(done), .illegal(illegal), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  alu_exec_unit #(.DATA_WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .ALUOp(alu_op), .ALUFunction(alu_fn),
    .shamt(shamt16), .a(a16), .b(b16), .result(result16), .zero(zero16), .busy(busy16),
    .done(done16), .illegal(illegal16), .div_zero(div_zero16), .hi(hi16), .lo(lo16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [31:0] va, input logic [31:0] vb);
    alu_op = op; alu_fn = fn; shamt = sh; a = va; b = vb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts busy cycles after an iterative issue; optionally raises start once
  // while busy so that the issue lands on posedge k+inject.
  task automatic run_iter(input int inject, output int cnt, output bit seen_done);
    cnt = 0;
    seen_done = 1'b0;
    while (busy && cnt < 100) begin
      if (done) seen_done = 1'b1;
      start = (cnt == inject - 1);
      cnt++;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start16 = 1'b0;
    alu_op = 3'b000; alu_fn = 6'b0; shamt = '0; shamt16 = '0;
    a = '0; b = '0; a16 = '0; b16 = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_result", result, 32'h0);
    chk("rst_zero", 32'(zero), 32'h1);
    chk("rst_busy_done", {30'h0, busy, done}, 32'h0);
    chk("rst_hi_lo", hi | lo, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Abort a MULTU with reset a few cycles in
    issue(3'b111, 6'b011001, 5'd0, 32'd7, 32'd9);
    chk("mul_busy_start", 32'(busy), 32'h1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_hi_lo", hi | lo, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    early = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) early = 1'b1;
    end
    chk("abort_no_done", 32'(early), 32'h0);

    issue(3'b111, 6'b100000, 5'd0, 32'd5, 32'd3);
    chk("add_result", result, 32'd8);
    chk("add_zero_done", {30'h0, zero, done}, 32'h1);
    @(negedge clk);
    chk("add_done_pulse", 32'(done), 32'h0);
    chk("idle_hold", result, 32'd8);

    // Single-cycle sweep, issued back to back
    issue(3'b111, 6'b100010, 5'd0, 32'd3, 32'd3);
    chk("sub_result", result, 32'h0);
    chk("sub_zero", 32'(zero), 32'h1);
    issue(3'b111, 6'b101010, 5'd0, 32'hFFFFFFFF, 32'd1);
    chk("slt_neg", result, 32'h1);
    chk("slt_zero_done", {30'h0, zero, done}, 32'h1);
    issue(3'b111, 6'b101010, 5'd0, 32'd1, 32'hFFFFFFFF);
    chk("slt_pos", result, 32'h0);
    issue(3'b111, 6'b000000, 5'd4, 32'h0, 32'h1);
    chk("sll", result, 32'h10);
    issue(3'b111, 6'b000010, 5'd4, 32'h0, 32'h80000000);
    chk("srl", result, 32'h08000000);
    issue(3'b011, 6'b111111, 5'd0, 32'h0, 32'h1234);
    chk("lui", result, 32'h12340000);
    issue(3'b100, 6'b000000, 5'd0, 32'hFFFFFFFF, 32'h1);
    chk("addi_wrap", result, 32'h0);
    chk("addi_wrap_zero", 32'(zero), 32'h1);
    issue(3'b101, 6'b000000, 5'd0, 32'hF0F0_0000, 32'h0000_00FF);
    chk("ori", result, 32'hF0F0_00FF);
    issue(3'b110, 6'b000000, 5'd0, 32'hF0F0_1234, 32'h0000_FF0F);
    chk("andi", result, 32'h0000_1204);
    issue(3'b111, 6'b100111, 5'd0, 32'h0, 32'h0);
    chk("nor", result, 32'hFFFFFFFF);
    chk("nor_zero", 32'(zero), 32'h0);

    // MULTU max*max with an ADD issued at k+5 that must be ignored
    issue(3'b111, 6'b011001, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    alu_fn = 6'b100000; a = 32'd1; b = 32'd1;
    run_iter(5, n, early);
    chk("mul_busy_cycles", 32'(n), 32'd32);
    chk("mul_no_early_done", 32'(early), 32'h0);
    chk("mul_done", {30'h0, busy, done}, 32'h1);
    chk("mul_hi", hi, 32'hFFFFFFFE);
    chk("mul_lo", lo, 32'h00000001);
    chk("mul_result_kept", result, 32'hFFFFFFFF);
    @(negedge clk);
    chk("mul_done_pulse", 32'(done), 32'h0);

    // DIVU 100/7 then MFLO in the done cycle
    issue(3'b111, 6'b011011, 5'd0, 32'd100, 32'd7);
    run_iter(-1, n, early);
    chk("div_busy_cycles", 32'(n), 32'd32);
    chk("div_done", {30'h0, busy, done}, 32'h1);
    chk("div_lo", lo, 32'd14);
    chk("div_hi", hi, 32'd2);
    issue(3'b111, 6'b010010, 5'd0, 32'h0, 32'h0);
    chk("mflo", result, 32'd14);
    issue(3'b111, 6'b010000, 5'd0, 32'h0, 32'h0);
    chk("mfhi", result, 32'd2);

    issue(3'b111, 6'b011011, 5'd0, 32'd55, 32'd0);
    chk("divz_flags", {29'h0, busy, div_zero, done}, 32'h3);
    chk("divz_hi", hi, 32'd55);
    chk("divz_lo", lo, 32'hFFFFFFFF);
    chk("divz_result_kept", result, 32'd2);
    @(negedge clk);
    chk("divz_pulse", {30'h0, div_zero, done}, 32'h0);

    issue(3'b111, 6'b111111, 5'd0, 32'h1, 32'h1);
    chk("ill_flags", {29'h0, illegal, done, zero}, 32'h7);
    chk("ill_result", result, 32'h0);
    chk("ill_hi_lo", hi ^ lo, 32'd55 ^ 32'hFFFFFFFF);
    issue(3'b000, 6'b100000, 5'd0, 32'h1, 32'h1);
    chk("ill_aluop", 32'(illegal), 32'h1);
    @(negedge clk);
    chk("ill_pulse", 32'(illegal), 32'h0);

    // 16-bit instance: MULTU 0xFFFF * 2
    alu_op = 3'b111; alu_fn = 6'b011001; a16 = 16'hFFFF; b16 = 16'h0002; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    n = 0;
    while (busy16 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("mul16_busy_cycles", 32'(n), 32'd16);
    chk("mul16_done", 32'(done16), 32'h1);
    chk("mul16_hi", {16'h0, hi16}, 32'h0001);
    chk("mul16_lo", {16'h0, lo16}, 32'hFFFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
